// File: rtl/strela_input_stream.sv
// -----------------------------------------------------------------------------
// strela_input_stream
//
// Memory-read stream engine for one CGRA input node. A start pulse latches a
// start address, a word count and a byte stride. The engine then issues word
// reads on an OBI-style req/gnt/rvalid port and buffers the returned data in a
// small FIFO. The FIFO drives a valid/ready stream into the CGRA input node.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i, abort_i          one-cycle control pulses from the CSR block
//   addr_i, size_i, stride_i  transfer parameters, sampled on an accepted start
//   mem_req_o, mem_addr_o     read request and byte address
//   mem_gnt_i                 request accepted this cycle
//   mem_rvalid_i, mem_rdata_i in-order read response
//   data_o, valid_o, ready_i  output stream
//   busy_o, done_o            engine active / one-cycle completion pulse
// -----------------------------------------------------------------------------
module strela_input_stream #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] size_i,
  input  logic [15:0] stride_i,
  input  logic        abort_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        stride_q, stride_d;
  logic [13:0]        words_q, words_d;
  logic [13:0]        issued_q, issued_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               done_q, done_d;
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  logic start_acc, abort_act, gnt_fire, rsp_fire, push, pop, credit_ok;
  logic unused_size_lsbs;

  // Byte-granular size bits below a word carry no meaning here.
  assign unused_size_lsbs = ^size_i[1:0];

  // Abort beats start; in IDLE an abort is a no-op but still masks the start.
  assign start_acc = start_i & ~abort_i & (state_q == S_IDLE);
  assign abort_act = abort_i & (state_q != S_IDLE);
  assign gnt_fire  = mem_req_o & mem_gnt_i;
  // Nothing is in flight after reset, so stray responses are ignored.
  assign rsp_fire  = mem_rvalid_i & (outstanding_q != '0);
  assign push      = rsp_fire & ~abort_act & ((state_q == S_REQ) || (state_q == S_DRAIN));
  assign pop       = valid_o & ready_i;
  // Credit counts reads in flight plus buffered words, so every response is
  // guaranteed a free FIFO slot and a pending request can never be withdrawn.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count_q}) < DEPTH;

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      words_q       <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      words_q       <= words_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      done_q        <= done_d;
    end
  end

  // NOTE: the FIFO storage has no reset; validity is tracked by the count and
  // data_o is forced to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, address and FIFO pointers
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    addr_d        = addr_q;
    stride_d      = stride_q;
    words_d       = words_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q;
    fifo_count_d  = fifo_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (start_acc) begin
      addr_d   = addr_i;
      stride_d = stride_i;
      words_d  = size_i[15:2];
      issued_d = '0;
    end else if (gnt_fire) begin
      addr_d   = addr_q + {16'h0000, stride_q};
      issued_d = issued_q + 14'd1;
    end

    case ({gnt_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (abort_act) begin
      fifo_count_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = (size_i[15:2] == 14'd0) ? S_DRAIN : S_REQ;
        end
      end
      S_REQ: begin
        if (abort_act) begin
          state_d = (outstanding_d != '0) ? S_FLUSH : S_IDLE;
        end else if (gnt_fire && (issued_d == words_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_act) begin
          state_d = (outstanding_d != '0) ? S_FLUSH : S_IDLE;
        end else if ((outstanding_d == '0) && (fifo_count_d == '0)) begin
          // Judged on next-cycle values so done lands one cycle after the
          // final pop rather than two.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        if (outstanding_d == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o  = (state_q == S_REQ) && credit_ok;
    mem_addr_o = addr_q;
    valid_o    = (fifo_count_q != '0);
    data_o     = valid_o ? fifo_mem[rd_ptr_q] : 32'h0000_0000;
    busy_o     = (state_q != S_IDLE);
    done_o     = done_q;
  end

endmodule

// File: tb/tb_strela_input_stream.sv
// -----------------------------------------------------------------------------
// tb_strela_input_stream
//
// Directed bench for strela_input_stream. A memory model grants requests and
// answers one cycle later with data derived from the requested address.
// Expected addresses and stream words are queued when a start is driven and
// popped as grants and stream handshakes happen.
// -----------------------------------------------------------------------------
module tb_strela_input_stream;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] addr_i;
  logic [15:0] size_i;
  logic [15:0] stride_i;
  logic        abort_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  strela_input_stream #(.FIFO_DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .addr_i       (addr_i),
    .size_i       (size_i),
    .stride_i     (stride_i),
    .abort_i      (abort_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] rsp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  int stall_at = 0;
  int stall_left = 0;
  bit rsp_hold = 1'b0;
  bit hold_pending = 1'b0;
  logic [31:0] hold_addr = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample mid-cycle, then drive the memory side after the edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk_i);
    if (hold_pending) begin
      check("req_hold", 32'(mem_req_o), 32'd1);
      check("addr_hold", mem_addr_o, hold_addr);
    end
    if (mem_req_o === 1'b1 && mem_gnt_i) begin
      grant_cnt++;
      check("grant_pending", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) begin
        e = exp_addr.pop_front();
        check("grant_addr", mem_addr_o, e);
      end
      rsp_q.push_back(mem_data(mem_addr_o));
    end
    hold_pending = (mem_req_o === 1'b1) && !mem_gnt_i && !abort_i && !rst_i;
    hold_addr    = mem_addr_o;
    if (valid_o === 1'b1 && ready_i) begin
      pop_cnt++;
      last_pop_cyc = cyc;
      check("pop_pending", 32'(exp_data.size() > 0), 32'd1);
      if (exp_data.size() > 0) begin
        e = exp_data.pop_front();
        check("stream_data", data_o, e);
      end
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (!rsp_hold && rsp_q.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rsp_q.pop_front();
    end
    mem_gnt_i = 1'b1;
    if (stall_left > 0 && grant_cnt == stall_at && mem_req_o === 1'b1) begin
      mem_gnt_i = 1'b0;
      stall_left--;
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] s, input logic [15:0] st);
    logic [31:0] ad;
    ad = a;
    for (int i = 0; i < int'(s[15:2]); i++) begin
      exp_addr.push_back(ad);
      exp_data.push_back(mem_data(ad));
      ad = ad + {16'h0000, st};
    end
    start_i  = 1'b1;
    addr_i   = a;
    size_i   = s;
    stride_i = st;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit chk_timing);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    if (chk_timing) check("done_timing", 32'(done_cyc), 32'(last_pop_cyc + 1));
    check("idle_after_done", 32'(busy_o), 32'd0);
    tick();
    check("done_single", 32'(done_cnt - d0), 32'd1);
    check("queues_drained", 32'(exp_addr.size() + exp_data.size()), 32'd0);
  endtask

  initial begin
    int g0, p0, d0;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    addr_i       = '0;
    size_i       = '0;
    stride_i     = '0;
    abort_i      = 1'b0;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    ready_i      = 1'b1;

    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);

    // Basic stream: 20 words, stride 4
    g0 = grant_cnt; p0 = pop_cnt;
    do_start(32'h8000_0000, 16'd80, 16'd4);
    check("start_req", 32'(mem_req_o), 32'd1);
    check("start_addr", mem_addr_o, 32'h8000_0000);
    run_until_done(200, 1'b1);
    check("basic_grants", 32'(grant_cnt - g0), 32'd20);
    check("basic_pops", 32'(pop_cnt - p0), 32'd20);

    // Back-pressure: credit limits reads to the FIFO depth
    ready_i = 1'b0;
    g0 = grant_cnt; p0 = pop_cnt;
    do_start(32'h0000_1000, 16'd40, 16'd8);
    repeat (30) tick();
    check("bp_grants", 32'(grant_cnt - g0), 32'd4);
    check("bp_req_low", 32'(mem_req_o), 32'd0);
    check("bp_valid", 32'(valid_o), 32'd1);
    check("bp_head", data_o, exp_data[0]);
    ready_i = 1'b1;
    run_until_done(200, 1'b1);
    check("bp_all_grants", 32'(grant_cnt - g0), 32'd10);
    check("bp_pops", 32'(pop_cnt - p0), 32'd10);

    // Grant stall on the third request
    g0 = grant_cnt;
    stall_at = grant_cnt + 2;
    stall_left = 5;
    do_start(32'h0000_2000, 16'd24, 16'd12);
    run_until_done(200, 1'b1);
    check("stall_used", 32'(stall_left), 32'd0);
    check("stall_grants", 32'(grant_cnt - g0), 32'd6);

    // Zero-size transfer
    g0 = grant_cnt;
    do_start(32'h0000_3000, 16'd3, 16'd4);
    check("zero_busy_t1", 32'(busy_o), 32'd1);
    check("zero_req_t1", 32'(mem_req_o), 32'd0);
    check("zero_done_t1", 32'(done_o), 32'd0);
    tick();
    check("zero_done_t2", 32'(done_o), 32'd1);
    check("zero_busy_t2", 32'(busy_o), 32'd0);
    tick();
    check("zero_done_t3", 32'(done_o), 32'd0);
    check("zero_grants", 32'(grant_cnt - g0), 32'd0);

    // Start while busy is ignored
    g0 = grant_cnt; p0 = pop_cnt;
    do_start(32'h0000_4000, 16'd16, 16'd4);
    tick();
    start_i = 1'b1; addr_i = 32'h9999_0000; size_i = 16'd64; stride_i = 16'd4;
    tick();
    start_i = 1'b0;
    run_until_done(100, 1'b1);
    repeat (3) tick();
    check("ign_req", 32'(mem_req_o), 32'd0);
    check("ign_busy", 32'(busy_o), 32'd0);
    check("ign_grants", 32'(grant_cnt - g0), 32'd4);
    check("ign_pops", 32'(pop_cnt - p0), 32'd4);

    // Abort with two reads outstanding
    rsp_hold = 1'b1;
    g0 = grant_cnt; d0 = done_cnt;
    stall_at = grant_cnt + 2;
    stall_left = 100;
    do_start(32'h0000_5000, 16'd32, 16'd4);
    tick();
    tick();
    check("abort_inflight", 32'(grant_cnt - g0), 32'd2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    stall_left = 0;
    exp_addr.delete();
    exp_data.delete();
    check("abort_req", 32'(mem_req_o), 32'd0);
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd1);
    rsp_hold = 1'b0;
    tick();
    check("flush_busy_rsp1", 32'(busy_o), 32'd1);
    tick();
    check("flush_busy_rsp2", 32'(busy_o), 32'd1);
    tick();
    check("flush_busy_end", 32'(busy_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_no_done", 32'(done_cnt - d0), 32'd0);
    p0 = pop_cnt;
    do_start(32'h0000_6000, 16'd12, 16'd4);
    check("restart_addr", mem_addr_o, 32'h0000_6000);
    run_until_done(100, 1'b1);
    check("restart_pops", 32'(pop_cnt - p0), 32'd3);

    // Address wrap
    g0 = grant_cnt;
    do_start(32'hFFFF_FFF8, 16'd16, 16'd4);
    check("wrap_start", mem_addr_o, 32'hFFFF_FFF8);
    run_until_done(100, 1'b1);
    check("wrap_grants", 32'(grant_cnt - g0), 32'd4);

    // Reset mid-transfer; late responses must be ignored
    rsp_hold = 1'b1;
    ready_i = 1'b0;
    g0 = grant_cnt;
    do_start(32'h0000_7000, 16'd64, 16'd4);
    repeat (6) tick();
    check("mid_grants", 32'(grant_cnt - g0), 32'd4);
    rst_i = 1'b1;
    tick();
    check("mid_rst_req", 32'(mem_req_o), 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    rsp_hold = 1'b0;
    ready_i = 1'b1;
    repeat (6) tick();
    check("late_rsp_valid", 32'(valid_o), 32'd0);
    check("late_rsp_busy", 32'(busy_o), 32'd0);
    p0 = pop_cnt;
    do_start(32'h0000_8000, 16'd8, 16'd4);
    run_until_done(100, 1'b1);
    check("post_rst_pops", 32'(pop_cnt - p0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
